// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters.
// Round-robin at message granularity. A grant ends on a byte flagged last, after
// MAX_BURST bytes, or when the owner holds req_valid low for STALL_TIMEOUT cycles.
//
// Handshake: a byte moves from requester i when req_valid[i] && req_ready[i] are
// both high at a rising edge. req_ready is only ever raised for the granted
// requester, in FETCH, while the transmitter is idle. Requesters keep valid/data
// stable until accepted; valid of non-granted requesters is only used to arbitrate.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_BURST     = 64,
  parameter int STALL_TIMEOUT = 1024,
  parameter int BUSY_TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_trigger,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_busy_timeout,
  output logic [1:0]                    dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_TIMEOUT - 1);
  localparam logic [BW-1:0] BUSY_LIM  = BW'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]    BURST_LIM = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t state, state_d;

  logic [GW-1:0]         rr_last;
  logic [7:0]            burst_cnt;
  logic [SW-1:0]         stall_cnt;
  logic [BW-1:0]         busy_cnt;
  logic                  last_q;

  logic [GW-1:0]         winner;
  logic                  any_valid;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept;
  logic                  msg_end;

  logic do_grant, do_accept, do_release, do_resume;
  logic stall_inc, busy_inc, set_err, byte_done;

  assign dbg_state = state;
  assign accept    = (state == S_FETCH) && g_valid && !tx_busy;
  assign msg_end   = last_q || (burst_cnt == BURST_LIM);

  // Round-robin pick: first valid requester after rr_last, wrapping around.
  always_comb begin
    winner    = rr_last;
    any_valid = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_valid && req_valid[i] && ((int'(rr_last) + off) % NUM_REQ == i)) begin
          winner    = GW'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

  // Select the granted requester's valid/data/last and drive its ready bit.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        if (state == S_FETCH) req_ready[i] = req_valid[i] && !tx_busy;
      end
    end
  end

  // Next-state and control strobes for the datapath registers.
  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_accept  = 1'b0;
    do_release = 1'b0;
    do_resume  = 1'b0;
    stall_inc  = 1'b0;
    busy_inc   = 1'b0;
    set_err    = 1'b0;
    byte_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          do_grant = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (accept) begin
          do_accept = 1'b1;
          state_d   = S_WAIT_HI;
        end else if (!g_valid) begin
          if (stall_cnt == STALL_LIM) begin
            do_release = 1'b1;
            state_d    = S_IDLE;
          end else begin
            stall_inc = 1'b1;
          end
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (busy_cnt == BUSY_LIM) begin
          // Transmitter never acknowledged: flag it and treat the byte as sent.
          set_err   = 1'b1;
          byte_done = 1'b1;
        end else begin
          busy_inc = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) byte_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (byte_done) begin
      if (msg_end) begin
        do_release = 1'b1;
        state_d    = S_IDLE;
      end else begin
        do_resume = 1'b1;
        state_d   = S_FETCH;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Grant, byte, counter and error registers driven by the control strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_trigger       <= 1'b0;
      tx_data          <= '0;
      grant_active     <= 1'b0;
      grant_id         <= '0;
      err_busy_timeout <= 1'b0;
      rr_last          <= GW'(NUM_REQ - 1);
      burst_cnt        <= '0;
      stall_cnt        <= '0;
      busy_cnt         <= '0;
      last_q           <= 1'b0;
    end else begin
      tx_trigger <= do_accept;
      if (do_grant) begin
        grant_id     <= winner;
        grant_active <= 1'b1;
        burst_cnt    <= '0;
        stall_cnt    <= '0;
      end
      if (do_accept) begin
        tx_data   <= g_data;
        last_q    <= g_last;
        burst_cnt <= burst_cnt + 8'd1;
        busy_cnt  <= '0;
      end
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (busy_inc)  busy_cnt  <= busy_cnt + 1'b1;
      if (set_err)   err_busy_timeout <= 1'b1;
      if (do_resume) stall_cnt <= '0;
      if (do_release) begin
        rr_last      <= grant_id;
        grant_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized message mixes for
// uart_tx_arbiter, checked against a message-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 3;
  localparam int DW            = 8;
  localparam int MAX_BURST     = 4;
  localparam int STALL_TIMEOUT = 20;
  localparam int BUSY_TIMEOUT  = 16;
  localparam int BUSY_LEN      = 10;
  localparam int W             = DW + 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_trigger;
  logic [DW-1:0]          tx_data;
  logic                   tx_busy;
  logic                   grant_active;
  logic [1:0]             grant_id;
  logic                   err_busy_timeout;
  logic [1:0]             dbg_state;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST),
    .STALL_TIMEOUT(STALL_TIMEOUT), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_trigger(tx_trigger), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_active(grant_active), .grant_id(grant_id),
    .err_busy_timeout(err_busy_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bench state ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [DW:0]   src_q [NUM_REQ][$];   // {last, data} still to be offered
  logic [DW:0]   mdl_q [NUM_REQ][$];   // reference-model copy
  int            mdl_rr;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  int            trig_cyc_q[$];
  int            busy_fall_q[$];
  int            ga_fall_q[$];
  int            err_rise_q[$];

  bit            busy_en = 1'b1;
  int            busy_left = 0;
  logic          prev_busy = 1'b0, prev_ga = 1'b0, prev_trig = 1'b0, prev_err = 1'b0;
  logic [DW-1:0] held_data = '0;
  int            trig_err = 0, stab_err = 0, ready_err = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); trig_cyc_q.delete();
    busy_fall_q.delete(); ga_fall_q.delete(); err_rise_q.delete();
  endtask

  task automatic push_byte(input int r, input logic [DW-1:0] d, input bit last);
    src_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic send_rand_msg(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom_range(0, 255)), k == len - 1);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Message-level reference: each turn goes to the next requester (after the
  // previous owner) holding data; it sends until last, MAX_BURST bytes, or it runs dry.
  task automatic model_run();
    int win, n, c;
    logic [DW:0] item;
    bit done;
    forever begin
      win = -1;
      for (int off = 1; off <= NUM_REQ; off++) begin
        c = (mdl_rr + off) % NUM_REQ;
        if (win < 0 && mdl_q[c].size() > 0) win = c;
      end
      if (win < 0) break;
      n = 0;
      done = 1'b0;
      while (!done) begin
        item = mdl_q[win].pop_front();
        exp_q.push_back({2'(win), item[DW-1:0]});
        n++;
        done = item[DW] || (n == MAX_BURST) || (mdl_q[win].size() == 0);
      end
      mdl_rr = win;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    repeat (3) step();
    while ((pending() || grant_active || tx_busy) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 32'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    busy_left = 0;
    tx_busy   = 1'b0;
    prev_busy = 1'b0;
    repeat (2) step();
    rst    = 1'b0;
    mdl_rr = NUM_REQ - 1;
  endtask

  // ---------------- driver / uart_tx model / monitor (negedge) ----------------
  task automatic bfm_step();
    logic [DW:0] head;
    if (tx_trigger) begin
      if (prev_trig) trig_err++;
      obs_q.push_back({grant_id, tx_data});
      trig_cyc_q.push_back(cyc);
      if (src_q[grant_id].size() > 0) void'(src_q[grant_id].pop_front());
      held_data = tx_data;
      if (busy_en) busy_left = BUSY_LEN;
    end else if (tx_busy && tx_data !== held_data) begin
      stab_err++;
    end
    if ($countones(req_ready) > 1) ready_err++;
    prev_trig = tx_trigger;
    if (prev_ga && !grant_active) ga_fall_q.push_back(cyc);
    prev_ga = grant_active;
    if (!prev_err && err_busy_timeout) err_rise_q.push_back(cyc);
    prev_err = err_busy_timeout;
    tx_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (prev_busy && !tx_busy) busy_fall_q.push_back(cyc);
    prev_busy = tx_busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        head = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = head[DW-1:0];
        req_last[i]           = head[DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    forever begin
      @(negedge clk);
      bfm_step();
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    // Reset state
    repeat (3) step();
    check("rst_trigger",  32'(tx_trigger), 32'(0));
    check("rst_ready",    32'(req_ready), 32'(0));
    check("rst_grant",    32'(grant_active), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_err",      32'(err_busy_timeout), 32'(0));
    check("rst_tx_data",  32'(tx_data), 32'(0));
    check("rst_state",    32'(dbg_state), 32'(0));
    rst    = 1'b0;
    mdl_rr = NUM_REQ - 1;

    // Single requester sends "OK\n"
    clear_logs();
    push_byte(0, 8'h4F, 1'b0);
    push_byte(0, 8'h4B, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    model_run();
    wait_done("t1_done", 2000);
    compare_stream("t1_bytes");
    check("t1_triggers", 32'(trig_cyc_q.size()), 32'(3));
    check("t1_release_time", (ga_fall_q.size() > 0) ? ga_fall_q[0] : -1,
          (busy_fall_q.size() >= 3) ? busy_fall_q[2] + 1 : -2);

    // All three valid from reset, 2-byte messages, requester 0 has two
    pulse_reset();
    clear_logs();
    send_rand_msg(0, 2);
    send_rand_msg(0, 2);
    send_rand_msg(1, 2);
    send_rand_msg(2, 2);
    model_run();
    wait_done("t2_done", 3000);
    compare_stream("t2_order");

    // Burst limit: requester 1 streams 10 bytes with no last, requester 2 waits
    clear_logs();
    for (int k = 0; k < 10; k++) push_byte(1, 8'(8'h10 + k), 1'b0);
    send_rand_msg(2, 3);
    model_run();
    wait_done("t3_done", 3000);
    compare_stream("t3_burst");

    // Stall: requester 0 goes quiet after one byte, requester 1 waits
    clear_logs();
    push_byte(0, 8'($urandom_range(0, 255)), 1'b0);
    send_rand_msg(1, 1);
    model_run();
    wait_done("t4_done", 2000);
    compare_stream("t4_stall");
    check("t4_stall_time", (ga_fall_q.size() > 0) ? ga_fall_q[0] : -1,
          (busy_fall_q.size() > 0) ? busy_fall_q[0] + 1 + STALL_TIMEOUT : -2);

    // Transmitter never goes busy
    busy_en = 1'b0;
    clear_logs();
    send_rand_msg(2, 2);
    send_rand_msg(0, 1);
    model_run();
    wait_done("t5_done", 2000);
    compare_stream("t5_no_busy");
    check("t5_err_time", (err_rise_q.size() > 0) ? err_rise_q[0] : -1,
          (trig_cyc_q.size() > 0) ? trig_cyc_q[0] + BUSY_TIMEOUT : -2);
    busy_en = 1'b1;
    repeat (5) step();
    check("t5_err_sticky", 32'(err_busy_timeout), 32'(1));

    // Randomized message mixes
    for (int round = 0; round < 4; round++) begin
      clear_logs();
      for (int r = 0; r < NUM_REQ; r++) begin
        n = $urandom_range(0, 2);
        for (int m = 0; m < n; m++) send_rand_msg(r, $urandom_range(1, 6));
      end
      model_run();
      wait_done("t6_done", 4000);
      compare_stream("t6_rand");
    end
    check("t6_err_sticky", 32'(err_busy_timeout), 32'(1));
    check("trig_one_cycle", 32'(trig_err), 32'(0));
    check("data_stable", 32'(stab_err), 32'(0));
    check("ready_onehot", 32'(ready_err), 32'(0));

    // Reset in WAIT_LO mid-message
    clear_logs();
    send_rand_msg(1, 3);
    n = 0;
    while (dbg_state != 2'd3 && n < 200) begin
      step();
      n++;
    end
    check("t7_reach_wait_lo", 32'(dbg_state), 32'(3));
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_trigger", 32'(tx_trigger), 32'(0));
    check("t7_rst_ready",   32'(req_ready), 32'(0));
    check("t7_rst_grant",   32'(grant_active), 32'(0));
    check("t7_rst_err",     32'(err_busy_timeout), 32'(0));
    check("t7_rst_state",   32'(dbg_state), 32'(0));
    pulse_reset();
    clear_logs();
    send_rand_msg(1, 2);
    send_rand_msg(0, 2);
    model_run();
    wait_done("t7_done", 2000);
    compare_stream("t7_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
